phoenix_router_p: RTL and testbench

PHOENIX_ROUTER_P -- requirements
Module: phoenix_router_p

---
 rtl/phoenix_router_p.sv | 253 +++++++++++++++++++++++++
 tb/tb_phoenix_router_p.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/phoenix_router_p.sv
// phoenix_router_p: 5-port wormhole router, XY routing, one shared switch-control FSM.
// Define PHOENIX_RR_ARB_EN for round-robin arbitration; otherwise fixed priority E>W>N>S>L.
module phoenix_router_p #(
    parameter int unsigned       FLIT_W    = 16,
    parameter int unsigned       BUF_DEPTH = 4,
    parameter logic [FLIT_W-1:0] ADDR      = 16'h0101
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [4:0]          rx,
    input  logic [5*FLIT_W-1:0] data_in,
    output logic [4:0]          credit_o,
    output logic [4:0]          tx,
    output logic [5*FLIT_W-1:0] data_out,
    input  logic [4:0]          credit_i
);
    localparam int unsigned NumPorts = 5;
    localparam int unsigned PtrW     = $clog2(BUF_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned HalfW    = FLIT_W / 2;

    localparam logic [2:0] PortEast  = 3'd0;
    localparam logic [2:0] PortWest  = 3'd1;
    localparam logic [2:0] PortNorth = 3'd2;
    localparam logic [2:0] PortSouth = 3'd3;
    localparam logic [2:0] PortLocal = 3'd4;

    localparam logic [HalfW-1:0] LocX = ADDR[FLIT_W-1:HalfW];
    localparam logic [HalfW-1:0] LocY = ADDR[HalfW-1:0];

    typedef enum logic [1:0] {StIdle, StArb, StRoute, StGrant} state_e;
    typedef enum logic [1:0] {PhHeader, PhSize, PhBody} phase_e;

    // Input FIFOs
    logic [FLIT_W-1:0] fifo_mem_q [NumPorts][BUF_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q   [NumPorts];
    logic [PtrW-1:0]   rd_ptr_q   [NumPorts];
    logic [CntW-1:0]   count_q    [NumPorts];
    logic [FLIT_W-1:0] head       [NumPorts];
    logic [4:0]        empty;
    logic [4:0]        push;
    logic [4:0]        pop;

    // Per-input packet tracking
    phase_e            phase_q    [NumPorts];
    logic [FLIT_W-1:0] remain_q   [NumPorts];
    logic [4:0]        last;
    logic [4:0]        pending;

    // Switch state
    state_e            state_q;
    logic [2:0]        sel_q;
    logic [2:0]        route_q;
    logic [4:0]        out_busy_q;
    logic [2:0]        out_src_q  [NumPorts];
    logic [4:0]        in_conn_q;

    logic [2:0]        arb_pick;
    logic              arb_found;
    logic [FLIT_W-1:0] sel_hdr;
    logic [HalfW-1:0]  dst_x;
    logic [HalfW-1:0]  dst_y;
    logic [2:0]        route_dir;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            empty[p]    = (count_q[p] == '0);
            credit_o[p] = (count_q[p] != CntW'(BUF_DEPTH));
            push[p]     = rx[p] && credit_o[p];
            head[p]     = fifo_mem_q[p][rd_ptr_q[p]];
            pending[p]  = !in_conn_q[p] && (phase_q[p] == PhHeader) && !empty[p];
        end
    end

    // Crossbar: each busy output follows the FIFO head of its source input.
    always_comb begin
        tx       = '0;
        data_out = '0;
        pop      = '0;
        for (int o = 0; o < NumPorts; o++) begin
            if (out_busy_q[o]) begin
                tx[o]                          = !empty[out_src_q[o]];
                data_out[o*FLIT_W +: FLIT_W]   = head[out_src_q[o]];
                if (tx[o] && credit_i[o]) begin
                    pop[out_src_q[o]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            last[p] = pop[p] &&
                      (((phase_q[p] == PhSize) && (head[p] == '0)) ||
                       ((phase_q[p] == PhBody) && (remain_q[p] == FLIT_W'(1))));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < NumPorts; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (push[p]) begin
                    fifo_mem_q[p][wr_ptr_q[p]] <= data_in[p*FLIT_W +: FLIT_W];
                    wr_ptr_q[p]                <= wr_ptr_q[p] + 1'b1;
                end
                if (pop[p]) begin
                    rd_ptr_q[p] <= rd_ptr_q[p] + 1'b1;
                end
                if (push[p] && !pop[p]) begin
                    count_q[p] <= count_q[p] + 1'b1;
                end else if (pop[p] && !push[p]) begin
                    count_q[p] <= count_q[p] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < NumPorts; p++) begin
                phase_q[p]  <= PhHeader;
                remain_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (pop[p]) begin
                    unique case (phase_q[p])
                        PhHeader: phase_q[p] <= PhSize;
                        PhSize: begin
                            remain_q[p] <= head[p];
                            phase_q[p]  <= (head[p] == '0) ? PhHeader : PhBody;
                        end
                        PhBody: begin
                            remain_q[p] <= remain_q[p] - 1'b1;
                            if (remain_q[p] == FLIT_W'(1)) begin
                                phase_q[p] <= PhHeader;
                            end
                        end
                        default: phase_q[p] <= PhHeader;
                    endcase
                end
            end
        end
    end

`ifdef PHOENIX_RR_ARB_EN
    logic [2:0] rr_ptr_q;
    logic [2:0] rr_idx;

    // Scan starts just after the last granted input and wraps LOCAL -> EAST.
    always_comb begin
        arb_pick  = PortEast;
        arb_found = 1'b0;
        rr_idx    = rr_ptr_q;
        for (int k = 0; k < NumPorts; k++) begin
            rr_idx = (rr_idx == PortLocal) ? PortEast : rr_idx + 3'd1;
            if (!arb_found && pending[rr_idx]) begin
                arb_found = 1'b1;
                arb_pick  = rr_idx;
            end
        end
    end
`else
    always_comb begin
        arb_pick  = PortEast;
        arb_found = 1'b0;
        for (int k = 0; k < NumPorts; k++) begin
            if (!arb_found && pending[k]) begin
                arb_found = 1'b1;
                arb_pick  = 3'(k);
            end
        end
    end
`endif

    always_comb begin
        sel_hdr = head[sel_q];
        dst_x   = sel_hdr[FLIT_W-1:HalfW];
        dst_y   = sel_hdr[HalfW-1:0];
        if (dst_x > LocX) begin
            route_dir = PortEast;
        end else if (dst_x < LocX) begin
            route_dir = PortWest;
        end else if (dst_y > LocY) begin
            route_dir = PortNorth;
        end else if (dst_y < LocY) begin
            route_dir = PortSouth;
        end else begin
            route_dir = PortLocal;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            sel_q      <= PortEast;
            route_q    <= PortEast;
            out_busy_q <= '0;
            in_conn_q  <= '0;
            for (int o = 0; o < NumPorts; o++) begin
                out_src_q[o] <= '0;
            end
`ifdef PHOENIX_RR_ARB_EN
            rr_ptr_q   <= PortLocal;
`endif
        end else begin
            // Teardown on the last flit's pop; GRANT never targets an output busy here.
            for (int o = 0; o < NumPorts; o++) begin
                if (out_busy_q[o] && last[out_src_q[o]]) begin
                    out_busy_q[o] <= 1'b0;
                end
            end
            for (int p = 0; p < NumPorts; p++) begin
                if (last[p]) begin
                    in_conn_q[p] <= 1'b0;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (|pending) begin
                        state_q <= StArb;
                    end
                end
                StArb: begin
                    if (arb_found) begin
                        sel_q <= arb_pick;
                    end
                    state_q <= StRoute;
                end
                StRoute: begin
                    route_q <= route_dir;
                    state_q <= out_busy_q[route_dir] ? StIdle : StGrant;
                end
                StGrant: begin
                    out_busy_q[route_q] <= 1'b1;
                    out_src_q[route_q]  <= sel_q;
                    in_conn_q[sel_q]    <= 1'b1;
`ifdef PHOENIX_RR_ARB_EN
                    rr_ptr_q            <= sel_q;
`endif
                    state_q             <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_phoenix_router_p.sv
// Scoreboard bench for phoenix_router_p: per-input stimulus queues, per-output expected queues.
module tb_phoenix_router_p;
    localparam int FW = 16;
    localparam int NP = 5;
    localparam int EAST = 0, WEST = 1, NORTH = 2, SOUTH = 3, LOCAL = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    rx, credit_o, tx, credit_i;
    logic [5*FW-1:0] data_in, data_out;

    phoenix_router_p #(.FLIT_W(FW), .BUF_DEPTH(4), .ADDR(16'h0101)) dut (
        .clock   (clock),
        .reset   (reset),
        .rx      (rx),
        .data_in (data_in),
        .credit_o(credit_o),
        .tx      (tx),
        .data_out(data_out),
        .credit_i(credit_i)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    logic [FW-1:0] in_q  [NP][$];
    logic [FW-1:0] exp_q [NP][$];
    logic       rand_cred  = 1'b0;
    logic [4:0] cred_force = 5'b11111;
    logic       mon_en     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int route(input logic [FW-1:0] h);
        logic [7:0] x;
        logic [7:0] y;
        x = h[15:8];
        y = h[7:0];
        if (x > 8'h01) return EAST;
        if (x < 8'h01) return WEST;
        if (y > 8'h01) return NORTH;
        if (y < 8'h01) return SOUTH;
        return LOCAL;
    endfunction

    task automatic send(input int p, input logic [FW-1:0] hdr, input int size,
                        input logic [FW-1:0] first_pl);
        int o;
        logic [FW-1:0] f;
        o = route(hdr);
        in_q[p].push_back(hdr);
        exp_q[o].push_back(hdr);
        in_q[p].push_back(FW'(size));
        exp_q[o].push_back(FW'(size));
        for (int i = 0; i < size; i++) begin
            f = (i == 0) ? first_pl : FW'($urandom);
            in_q[p].push_back(f);
            exp_q[o].push_back(f);
        end
    endtask

    function automatic int outstanding();
        int s = 0;
        for (int p = 0; p < NP; p++) s += in_q[p].size() + exp_q[p].size();
        return s;
    endfunction

    task automatic drain(input string tag);
        int k = 0;
        while (outstanding() > 0 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        check(tag, outstanding(), 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic flush_all();
        for (int p = 0; p < NP; p++) begin
            in_q[p].delete();
            exp_q[p].delete();
        end
    endtask

    // Input driver: present the head of each stimulus queue after every rising edge.
    always @(posedge clock) begin
        cyc++;
        #1;
        for (int p = 0; p < NP; p++) begin
            rx[p] = (in_q[p].size() > 0);
            data_in[p*FW +: FW] = rx[p] ? in_q[p][0] : '0;
        end
        credit_i = rand_cred ? 5'($urandom) : cred_force;
    end

    always @(negedge clock) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                if (rx[p] && credit_o[p] && in_q[p].size() > 0) void'(in_q[p].pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en && !reset) begin
            for (int o = 0; o < NP; o++) begin
                if (tx[o] && credit_i[o]) begin
                    if (exp_q[o].size() == 0) check($sformatf("extra_flit%0d", o),
                                                    exp_q[o].size(), 1);
                    else check($sformatf("out%0d", o), data_out[o*FW +: FW],
                               exp_q[o].pop_front());
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(posedge clock);
        #2 reset = 1'b1;
        flush_all();
        repeat (cycles) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("rst_tx", tx, 5'b0);
        check("rst_credit", credit_o, 5'b11111);
        check("rst_data", data_out[31:0], 32'h0);
        check("rst_data_hi", data_out[79:32], 48'h0);
    endtask

    initial begin
        int k;
        int hdr_cyc;
        reset   = 1'b1;
        rx      = '0;
        data_in = '0;
        credit_i = 5'b11111;
        do_reset(3);
        mon_en = 1'b1;

        // LOCAL -> NORTH, header shown on tx 4 edges after acceptance
        send(LOCAL, 16'h0002 | 16'h0100, 2, 16'hAAAA);
        void'(exp_q[NORTH].pop_back());
        void'(in_q[LOCAL].pop_back());
        in_q[LOCAL].push_back(16'hBBBB);
        exp_q[NORTH].push_back(16'hBBBB);
        k = 0;
        while (!(rx[LOCAL] && credit_o[LOCAL]) && k < 50) begin @(negedge clock); k++; end
        hdr_cyc = cyc + 1;
        k = 0;
        while (!tx[NORTH] && k < 50) begin @(negedge clock); k++; end
        check("lat_north", cyc - hdr_cyc, 4);
        check("lat_hdr", data_out[NORTH*FW +: FW], 16'h0102);
        drain("drain_local");

        // Fill WEST while its routed output (WEST, U-turn) is stalled
        cred_force = 5'b00000;
        send(WEST, 16'h0002, 3, 16'h1111);
        repeat (12) @(negedge clock);
        check("west_full", credit_o[WEST], 1'b0);
        check("west_backlog", in_q[WEST].size(), 1);
        check("west_hold_tx", tx[WEST], 1'b1);
        check("west_hold_data", data_out[WEST*FW +: FW], 16'h0002);
        cred_force = 5'b11111;
        k = 0;
        while (!(tx[WEST] && credit_i[WEST]) && k < 50) begin @(negedge clock); k++; end
        @(negedge clock);
        check("west_credit_back", credit_o[WEST], 1'b1);
        drain("drain_west");

        // Contention on LOCAL, twice
        for (int r = 0; r < 2; r++) begin
            send(EAST, 16'h0101, 3, 16'hE000 + 16'(r));
            send(SOUTH, 16'h0101, 2, 16'h5000 + 16'(r));
            drain($sformatf("drain_cont%0d", r));
        end

        // Zero-size packet from NORTH, then LOCAL reused by EAST
        send(NORTH, 16'h0101, 0, 16'h0);
        repeat (2) @(negedge clock);
        send(EAST, 16'h0101, 1, 16'hCAFE);
        drain("drain_zero");

        // All five outputs at once under random downstream backpressure
        rand_cred = 1'b1;
        send(WEST, 16'h0201, 3, 16'h0A01);
        send(EAST, 16'h0001, 2, 16'h0A02);
        send(SOUTH, 16'h0102, 4, 16'h0A03);
        send(NORTH, 16'h0100, 1, 16'h0A04);
        send(LOCAL, 16'h0101, 0, 16'h0);
        send(LOCAL, 16'h0201, 5, 16'h0A05);
        drain("drain_parallel");
        rand_cred = 1'b0;

        // Reset in the middle of a long packet
        send(LOCAL, 16'h0102, 10, 16'h7777);
        k = 0;
        while (exp_q[NORTH].size() > 8 && k < 100) begin @(negedge clock); k++; end
        check("mid_progress", exp_q[NORTH].size() <= 8, 1'b1);
        do_reset(1);
        send(WEST, 16'h0100, 2, 16'h4242);
        drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
